// File: rtl/lanes_pkg.sv
// Shared lane-combiner constants: byte width, idle filler, capture phase, lane count.
// Latency: n/a (package only).
// Backpressure: n/a.
package lanes_pkg;

  localparam int          BW_DEFAULT   = 8;
  localparam logic [7:0]  IDLE_DEFAULT = 8'h00;
  localparam int          NLANES       = 4;

  typedef logic [1:0] phase_t;

  // Edge on which all four lanes are sampled; lane 0 goes straight to the output.
  localparam phase_t PH_CAPTURE = 2'd3;

endpackage

// File: rtl/muxes_lane_hold.sv
// Per-lane holding register {valid, byte} with load enable and synchronous clear.
// Latency: 1 edge from load to q.
// Backpressure: none; load is unconditional when ld is high.
module lane_hold #(
  parameter int W = 9
) (
  input  logic         clk,
  input  logic         clr,
  input  logic         ld,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  // Clear wins over load so a reset on a capture edge leaves the lane empty.
  always_ff @(posedge clk) begin
    if (clr) begin
      q <= '0;
    end else if (ld) begin
      q <= d;
    end
  end

endmodule

// File: rtl/muxes.sv
// Interleaves four clk_f-rate byte lanes into one clk_4f byte stream, lane 0 first.
// Latency: lane k leaves k+1 edges after the capture edge; frames back-to-back every 4 edges.
// Backpressure: none; invalid lanes keep their slot and emit IDLE with validSalida low.
module muxes
  import lanes_pkg::*;
#(
  parameter int          BW   = BW_DEFAULT,
  parameter logic [BW-1:0] IDLE = BW'(IDLE_DEFAULT)
) (
  input  logic          clk_4f,
  input  logic          reset,
  input  logic [BW-1:0] Entrada0,
  input  logic [BW-1:0] Entrada1,
  input  logic [BW-1:0] Entrada2,
  input  logic [BW-1:0] Entrada3,
  input  logic          validEntrada0,
  input  logic          validEntrada1,
  input  logic          validEntrada2,
  input  logic          validEntrada3,
  output logic [BW-1:0] Salida,
  output logic          validSalida,
  output logic [1:0]    lane_sel,
  output logic          frame_start
);

  phase_t      phase;
  logic        capture;
  logic        primed;   // set by the first capture after reset; outputs stay at reset values until then
  phase_t      slot;
  logic [BW:0] lane_in [1:NLANES-1];
  logic [BW:0] hold_q  [1:NLANES-1];
  logic [BW:0] slot_q;

  assign capture    = (phase == PH_CAPTURE);
  assign slot       = phase + 2'd1;
  assign lane_in[1] = {validEntrada1, Entrada1};
  assign lane_in[2] = {validEntrada2, Entrada2};
  assign lane_in[3] = {validEntrada3, Entrada3};

  // Lanes 1..3 are parked until their slot comes up; lane 0 needs no holding.
  for (genvar k = 1; k < NLANES; k++) begin : g_hold
    lane_hold #(.W(BW + 1)) u_hold (
      .clk (clk_4f),
      .clr (reset),
      .ld  (capture),
      .d   (lane_in[k]),
      .q   (hold_q[k])
    );
  end

  // Pick the parked lane that owns the next slot (phase 0..2 -> lane 1..3).
  always_comb begin
    slot_q = '0;
    case (slot)
      2'd1:    slot_q = hold_q[1];
      2'd2:    slot_q = hold_q[2];
      2'd3:    slot_q = hold_q[3];
      default: slot_q = '0;
    endcase
  end

  // Phase counter and registered output slot; reset discards any partial frame.
  always_ff @(posedge clk_4f) begin
    if (reset) begin
      phase       <= 2'd0;
      primed      <= 1'b0;
      Salida      <= '0;
      validSalida <= 1'b0;
      lane_sel    <= 2'd0;
      frame_start <= 1'b0;
    end else begin
      phase <= phase + 2'd1;
      if (capture) begin
        primed      <= 1'b1;
        Salida      <= validEntrada0 ? Entrada0 : IDLE;
        validSalida <= validEntrada0;
        lane_sel    <= 2'd0;
        frame_start <= 1'b1;
      end else if (primed) begin
        Salida      <= slot_q[BW] ? slot_q[BW-1:0] : IDLE;
        validSalida <= slot_q[BW];
        lane_sel    <= slot;
        frame_start <= 1'b0;
      end
    end
  end

endmodule
